conv_mac_engine: RTL



---
 rtl/conv_mac_engine.sv | 87 ++++++++
 1 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: convolution-window multiply-accumulate with bias, optional ReLU and output saturation
// Ports: clk/rst; en (low aborts a window); relu_en/bias (taken on first tap);
// in_valid/in_ready/kernel_weight/in_pix tap handshake; write pulses on the last tap;
// out_valid/out_pix/sat result held until out_ack.
module conv_mac_engine #(
  parameter int DATA_W = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS = 1,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     relu_en,
  input  logic signed [OUT_W-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] kernel_weight,
  input  logic signed [DATA_W-1:0] in_pix,
  output logic                     write,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_pix,
  output logic                     sat,
  input  logic                     out_ack
);
  localparam int N = KERNEL_SIZE * KERNEL_SIZE * CHANNELS;
  localparam int CNT_W = N > 1 ? $clog2(N) : 1;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, bias_q, prod_x, bias_x, sum, sum_r;
  logic [CNT_W-1:0] cnt;
  logic relu_q, relu_x, take, last, abort, hi, lo;
  assign in_ready = en && state != HOLD && !rst;
  assign take = in_valid && in_ready;
  assign last = take && cnt == CNT_W'(N - 1);
  assign abort = state == ACCUM && !en;
  assign write = last;
  assign out_valid = state == HOLD;
  assign prod = kernel_weight * in_pix;
  assign prod_x = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // On the first tap the live bias/relu_en are used so a one-tap window completes straight from IDLE
  assign bias_x = state == IDLE ? {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} : bias_q;
  assign relu_x = state == IDLE ? relu_en : relu_q;
  assign sum = acc + prod_x + bias_x;
  assign sum_r = relu_x && sum[ACC_W-1] ? '0 : sum;
  assign hi = sum_r > MAX_V;
  assign lo = sum_r < MIN_V;
  always_comb begin
    state_nx = state;
    if (state == HOLD) state_nx = out_ack ? IDLE : HOLD;
    else if (last) state_nx = HOLD;
    else if (abort) state_nx = IDLE;
    else if (take) state_nx = ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      bias_q <= '0;
      relu_q <= 1'b0;
      out_pix <= '0;
      sat <= 1'b0;
    end else begin
      state <= state_nx;
      if (last || abort) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc + prod_x;
        cnt <= cnt + CNT_W'(1);
      end
      if (take && state == IDLE) begin
        bias_q <= bias_x;
        relu_q <= relu_en;
      end
      if (last) begin
        out_pix <= hi ? MAX_V[OUT_W-1:0] : lo ? MIN_V[OUT_W-1:0] : sum_r[OUT_W-1:0];
        sat <= hi || lo;
      end
    end
  end
endmodule
